// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the PC, addresses the combinational instruction ROM and registers the
// returned word into the IF/ID register. Unconditional jumps resolve here; jump-to-self halts.
module inst_fetch_unit #(
  parameter int              ADDR_W     = 8,
  parameter int              INST_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [7:0]      JMP_OPCODE = 8'h08
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] pc_addr,
  input  logic [INST_W-1:0] instruction,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [INST_W-1:0] ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  output logic              halted
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              is_jmp;
  logic [ADDR_W-1:0] jmp_target;

  assign is_jmp     = (instruction[31:24] == JMP_OPCODE);
  assign jmp_target = ADDR_W'(instruction[23:16]);
  assign pc_addr    = pc;

  // Priority: reset, redirect, stall, halt, normal fetch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      ir       <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
      halted   <= 1'b0;
      state    <= RUN;
    end else if (branch_taken) begin
      pc       <= branch_target;
      ir       <= '0;
      ir_valid <= 1'b0;
      halted   <= 1'b0;
      state    <= RUN;
    end else if (stall) begin
      pc       <= pc;
    end else if (state == HALT) begin
      ir_valid <= 1'b0;
    end else begin
      ir       <= instruction;
      ir_pc    <= pc;
      ir_valid <= 1'b1;
      if (is_jmp) begin
        // The jump word is still issued once before fetch parks on itself.
        pc <= jmp_target;
        if (jmp_target == pc) begin
          state  <= HALT;
          halted <= 1'b1;
        end
      end else begin
        pc <= pc + 1'b1;
      end
    end
  end

endmodule
